// File: rtl/salidas_pkg.sv
// salidas_pkg: store-mode codes, bus FSM states and store-mode decode
// shared by the buffered output-bus block.
package salidas_pkg;

  localparam logic [2:0] SEL_DIR_RY = 3'b011;
  localparam logic [2:0] SEL_RX_IDX = 3'b101;
  localparam logic [2:0] SEL_RX_RY  = 3'b110;

  typedef enum logic [1:0] {
    INACTIVO,
    ESCRIBE,
    LIBERA
  } estado_t;

  function automatic logic es_store(input logic [2:0] sel);
    return (sel == SEL_DIR_RY) ||
           (sel == SEL_RX_IDX) ||
           (sel == SEL_RX_RY);
  endfunction

endpackage

// File: rtl/salidas_fifo.sv
// salidas_fifo: synchronous FIFO of {DIR,DATO} pairs; push is
// refused while full and pop is ignored while empty.
module salidas_fifo #(
  parameter int W    = 16,
  parameter int PROF = 4
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_push,
  input  logic [W-1:0]           i_din,
  input  logic                   i_pop,
  output logic [W-1:0]           o_dout,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [$clog2(PROF):0]  o_count
);

  localparam int AW = $clog2(PROF);

  logic [W-1:0]  r_mem [PROF];
  logic [AW-1:0] r_wr;
  logic [AW-1:0] r_rd;
  logic [AW:0]   r_cnt;
  logic          w_push;
  logic          w_pop;

  assign o_full  = (r_cnt == (AW+1)'(PROF));
  assign o_empty = (r_cnt == '0);
  assign w_push  = i_push & ~o_full;
  assign w_pop   = i_pop & ~o_empty;
  assign o_dout  = r_mem[r_rd];
  assign o_count = r_cnt;

  // PROF is a power of two, so pointers wrap by plain overflow
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop)  r_rd <= r_rd + 1'b1;
      unique case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr] <= i_din;
  end

endmodule

// File: rtl/salidas_bus.sv
// salidas_bus: decodes store modes, queues {DIR,DATO} and drains them
// over an ESC/ACK write bus. Optional ACK timeout: SALIDAS_TIMEOUT_EN.
module salidas_bus
  import salidas_pkg::*;
#(
  parameter int ANCHO_DATO = 8,
  parameter int ANCHO_DIR  = 8,
  parameter int ANCHO_RY   = 3,
  parameter int PROF       = 4,
  parameter int TIMEOUT    = 15
) (
  input  logic                   CLK,
  input  logic                   RST_N,
  input  logic [2:0]             SELEC,
  input  logic [ANCHO_DATO-1:0]  RX_DATO,
  input  logic [ANCHO_RY-1:0]    RY,
  input  logic [ANCHO_DATO-1:0]  RY_DATO,
  input  logic                   VALIDO,
  output logic                   LISTO,
  output logic [ANCHO_DIR-1:0]   DIR_OUT,
  output logic [ANCHO_DATO-1:0]  DATO_OUT,
  output logic                   ESC,
  input  logic                   ACK,
  output logic [$clog2(PROF):0]  PENDIENTES,
  output logic                   ERROR
);

  localparam int FW = ANCHO_DIR + ANCHO_DATO;

  if (ANCHO_DIR > ANCHO_DATO || ANCHO_RY > ANCHO_DATO ||
      PROF < 2 || (PROF & (PROF - 1)) != 0 || TIMEOUT < 1)
  begin : g_param_check
    $error("salidas_bus: illegal parameter set");
  end

  estado_t               r_estado;
  estado_t               w_sig;
  logic [ANCHO_DIR-1:0]  r_dir;
  logic [ANCHO_DATO-1:0] r_dato;
  logic                  r_esc;
  logic [ANCHO_DIR-1:0]  w_dir;
  logic [ANCHO_DATO-1:0] w_dato;
  logic [FW-1:0]         w_cab;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_cargar;
  logic                  w_lleno;
  logic                  w_vacio;
  logic                  w_expira;

  always_comb begin
    w_dir  = '0;
    w_dato = '0;
    unique case (1'b1)
      (SELEC == SEL_DIR_RY): w_dir = RY_DATO[ANCHO_DIR-1:0];
      (SELEC == SEL_RX_IDX): begin
        w_dir  = RX_DATO[ANCHO_DIR-1:0];
        w_dato = ANCHO_DATO'(RY);
      end
      (SELEC == SEL_RX_RY): begin
        w_dir  = RX_DATO[ANCHO_DIR-1:0];
        w_dato = RY_DATO;
      end
      default: ;
    endcase
  end

  assign LISTO  = ~w_lleno;
  assign w_push = VALIDO & LISTO & es_store(SELEC);

  salidas_fifo #(
    .W    (FW),
    .PROF (PROF)
  ) u_fifo (
    .i_clk   (CLK),
    .i_rst_n (RST_N),
    .i_push  (w_push),
    .i_din   ({w_dir, w_dato}),
    .i_pop   (w_pop),
    .o_dout  (w_cab),
    .o_full  (w_lleno),
    .o_empty (w_vacio),
    .o_count (PENDIENTES)
  );

  always_comb begin
    w_sig    = r_estado;
    w_pop    = 1'b0;
    w_cargar = 1'b0;
    unique case (r_estado)
      INACTIVO: if (!w_vacio) begin
        w_cargar = 1'b1;
        w_sig    = ESCRIBE;
      end
      ESCRIBE: if (ACK || w_expira) begin
        w_pop = 1'b1;
        w_sig = LIBERA;
      end
      LIBERA:  w_sig = INACTIVO;
      default: w_sig = INACTIVO;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_estado <= INACTIVO;
      r_esc    <= 1'b0;
      r_dir    <= '0;
      r_dato   <= '0;
    end else begin
      r_estado <= w_sig;
      r_esc    <= (w_sig == ESCRIBE);
      if (w_cargar) begin
        r_dir  <= w_cab[FW-1:ANCHO_DATO];
        r_dato <= w_cab[ANCHO_DATO-1:0];
      end
    end
  end

  assign ESC      = r_esc;
  assign DIR_OUT  = r_dir;
  assign DATO_OUT = r_dato;

`ifdef SALIDAS_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] r_cuenta;
  logic          r_error;
  logic          w_tout;

  // counts ESC-high cycles; expiry on the TIMEOUT-th edge, ACK has priority
  assign w_expira = (r_estado == ESCRIBE) &&
                    (r_cuenta == CW'(TIMEOUT - 1));
  assign w_tout   = w_expira & ~ACK;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_cuenta <= '0;
      r_error  <= 1'b0;
    end else begin
      if (r_estado != ESCRIBE) r_cuenta <= '0;
      else if (!w_expira)      r_cuenta <= r_cuenta + 1'b1;
      if (w_tout) r_error <= 1'b1;
    end
  end

  assign ERROR = r_error;
`else
  assign w_expira = 1'b0;
  assign ERROR    = 1'b0;
`endif

endmodule

// File: tb/tb_salidas_bus.sv
// tb_salidas_bus: directed + random stimulus against a queue-based
// bus model; checks every output on each falling clock edge.
module tb_salidas_bus;

  localparam int PROF = 4;
  localparam int TOUT = 15;
`ifdef SALIDAS_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic       CLK = 1'b0;
  logic       RST_N = 1'b0;
  logic [2:0] SELEC = '0;
  logic [7:0] RX_DATO = '0;
  logic [2:0] RY = '0;
  logic [7:0] RY_DATO = '0;
  logic       VALIDO = 1'b0;
  logic       ACK = 1'b0;
  logic       LISTO;
  logic [7:0] DIR_OUT;
  logic [7:0] DATO_OUT;
  logic       ESC;
  logic [2:0] PENDIENTES;
  logic       ERROR;

  always #5 CLK = ~CLK;

  salidas_bus #(
    .ANCHO_DATO (8),
    .ANCHO_DIR  (8),
    .ANCHO_RY   (3),
    .PROF       (PROF),
    .TIMEOUT    (TOUT)
  ) dut (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .SELEC      (SELEC),
    .RX_DATO    (RX_DATO),
    .RY         (RY),
    .RY_DATO    (RY_DATO),
    .VALIDO     (VALIDO),
    .LISTO      (LISTO),
    .DIR_OUT    (DIR_OUT),
    .DATO_OUT   (DATO_OUT),
    .ESC        (ESC),
    .ACK        (ACK),
    .PENDIENTES (PENDIENTES),
    .ERROR      (ERROR)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // behavioural model: a queue of pending writes and a bus that may
  // start a new write only once it has been idle for a cycle after LIBERA
  logic [15:0] mq[$];
  bit          m_esc, m_err, m_full, m_pop;
  logic [7:0]  m_dir, m_dato;
  int          m_gap, m_wait;

  function automatic bit is_store(input logic [2:0] s);
    return s == 3'b011 || s == 3'b101 || s == 3'b110;
  endfunction

  function automatic logic [15:0] entry(input logic [2:0] s,
    input logic [7:0] rx, input logic [2:0] ry, input logic [7:0] rd);
    if (s == 3'b011) return {rd, 8'h00};
    if (s == 3'b101) return {rx, 5'b0, ry};
    return {rx, rd};
  endfunction

  always @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      mq.delete();
      m_esc = 0; m_err = 0; m_dir = 0; m_dato = 0;
      m_gap = 1; m_wait = 0;
    end else begin
      m_full = (mq.size() == PROF);
      m_pop  = 0;
      if (m_esc) begin
        m_wait++;
        if (ACK) m_pop = 1;
        else if (TO_EN && m_wait == TOUT) begin
          m_pop = 1;
          m_err = 1;
        end
        if (m_pop) begin
          m_esc = 0;
          m_gap = 0;
        end
      end else if (m_gap >= 1 && mq.size() > 0) begin
        m_esc = 1;
        m_wait = 0;
        {m_dir, m_dato} = mq[0];
      end else if (m_gap < 1) m_gap++;
      if (VALIDO && !m_full && is_store(SELEC))
        mq.push_back(entry(SELEC, RX_DATO, RY, RY_DATO));
      if (m_pop) void'(mq.pop_front());
    end
  end

  always @(negedge CLK) begin
    chk("esc", ESC, m_esc);
    chk("dir", DIR_OUT, m_dir);
    chk("dato", DATO_OUT, m_dato);
    chk("pend", PENDIENTES, mq.size());
    chk("listo", LISTO, mq.size() != PROF);
    chk("error", ERROR, m_err);
  end

  logic [15:0] wr_log[$];
  bit          p_esc = 0;

  always @(negedge CLK) begin
    if (ESC && !p_esc) wr_log.push_back({DIR_OUT, DATO_OUT});
    p_esc = ESC;
  end

  task automatic issue(input logic [2:0] s, input logic [7:0] rx,
                       input logic [2:0] ry, input logic [7:0] rd);
    @(negedge CLK);
    SELEC = s; RX_DATO = rx; RY = ry; RY_DATO = rd; VALIDO = 1'b1;
    @(negedge CLK);
    VALIDO = 1'b0;
  endtask

  task automatic wait_idle();
    int k;
    for (k = 0; k < 200; k++) begin
      @(negedge CLK);
      if (PENDIENTES == 0 && !ESC) break;
    end
    checks++;
    if (k >= 200) begin
      errors++;
      $display("FAIL idle_wait got=busy want=idle t=%0t", $time);
    end
  endtask

  int base, n;

  initial begin
    repeat (2) @(negedge CLK);
    chk("rst_pend", PENDIENTES, 0);
    chk("rst_esc", ESC, 0);
    chk("rst_dir", DIR_OUT, 0);
    chk("rst_err", ERROR, 0);
    RST_N = 1'b1;
    @(negedge CLK);
    chk("rst_listo", LISTO, 1);

    ACK = 1'b1;
    base = wr_log.size();
    issue(3'b110, 8'h20, 3'd0, 8'hA5);
    chk("t1_lat", ESC, 0);
    chk("t1_pend", PENDIENTES, 1);
    @(negedge CLK);
    chk("t1_esc", ESC, 1);
    chk("t1_dir", DIR_OUT, 8'h20);
    chk("t1_dato", DATO_OUT, 8'hA5);
    @(negedge CLK);
    chk("t1_esc_off", ESC, 0);
    chk("t1_pend0", PENDIENTES, 0);
    wait_idle();
    chk("t1_n", wr_log.size() - base, 1);

    base = wr_log.size();
    issue(3'b101, 8'h07, 3'b110, 8'hEE);
    issue(3'b011, 8'h99, 3'd1, 8'h3C);
    wait_idle();
    chk("t2_n", wr_log.size() - base, 2);
    if (wr_log.size() >= base + 2) begin
      chk("t2_w0", wr_log[base], 16'h0706);
      chk("t2_w1", wr_log[base+1], 16'h3C00);
    end

    ACK = 1'b0;
    base = wr_log.size();
    for (int i = 0; i < 5; i++)
      issue(3'b110, 8'h40 + 8'(i), 3'd0, 8'h50 + 8'(i));
    chk("t3_pend", PENDIENTES, 4);
    chk("t3_listo", LISTO, 0);
    ACK = 1'b1;
    wait_idle();
    chk("t3_n", wr_log.size() - base, 4);
    if (wr_log.size() >= base + 4)
      for (int i = 0; i < 4; i++)
        chk("t3_w", wr_log[base+i], {8'h40 + 8'(i), 8'h50 + 8'(i)});

    issue(3'b000, 8'h11, 3'd2, 8'h22);
    issue(3'b111, 8'h33, 3'd4, 8'h44);
    @(negedge CLK);
    chk("t4_pend", PENDIENTES, 0);
    chk("t4_esc", ESC, 0);

    repeat (400) begin
      @(negedge CLK);
      VALIDO  = 1'($urandom_range(0, 1));
      SELEC   = 3'($urandom);
      RX_DATO = 8'($urandom);
      RY      = 3'($urandom);
      RY_DATO = 8'($urandom);
      ACK     = ($urandom_range(0, 3) != 0);
    end
    VALIDO = 1'b0;
    ACK = 1'b1;
    wait_idle();

    ACK = 1'b0;
    for (int i = 0; i < 3; i++)
      issue(3'b110, 8'h61 + 8'(i), 3'd0, 8'h71 + 8'(i));
    chk("t5_pend3", PENDIENTES, 3);
    chk("t5_esc1", ESC, 1);
    #2 RST_N = 1'b0;
    #1;
    chk("t5_esc", ESC, 0);
    chk("t5_pend", PENDIENTES, 0);
    chk("t5_dir", DIR_OUT, 0);
    chk("t5_dato", DATO_OUT, 0);
    @(negedge CLK);
    #2 RST_N = 1'b1;
    base = wr_log.size();
    ACK = 1'b1;
    repeat (10) @(negedge CLK);
    chk("t5_nowr", wr_log.size() - base, 0);
    chk("t5_pend_after", PENDIENTES, 0);

`ifdef SALIDAS_TIMEOUT_EN
    ACK = 1'b0;
    issue(3'b110, 8'h81, 3'd0, 8'h91);
    issue(3'b110, 8'h82, 3'd0, 8'h92);
    n = ESC ? 1 : 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge CLK);
      if (ESC) n++;
      else break;
    end
    chk("to_cycles", n, TOUT);
    chk("to_err", ERROR, 1);
    for (int k = 0; k < 10; k++) begin
      @(negedge CLK);
      if (ESC) break;
    end
    chk("to_next_esc", ESC, 1);
    chk("to_next_dir", DIR_OUT, 8'h82);
    ACK = 1'b1;
    wait_idle();
    chk("to_sticky", ERROR, 1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/salidas_bus.md
Name: salidas_bus

Overview:
- Registered, buffered successor to the combinational output selector of the UAZ micro.
- Decodes the same SELEC store modes into an address/data pair and queues the pair in a PROF-deep FIFO.
- Drains the FIFO onto the external write bus with an ESC/ACK handshake.
- Sits between the execute stage (register-file outputs RX/RY) and the memory/peripheral bus. Decouples core issue from slow bus acknowledges.

Parameters:
ANCHO_DATO, 8, width of RX_DATO, RY_DATO, DATO_OUT
ANCHO_DIR, 8, width of DIR_OUT; must be <= ANCHO_DATO (address taken from low bits)
ANCHO_RY, 3, width of RY register index
PROF, 4, FIFO depth; power of two, >= 2
TIMEOUT, 15, ACK wait limit in cycles (used only with SALIDAS_TIMEOUT_EN)

Ports:
CLK  in  1  clock, rising edge
RST_N  in  1  asynchronous active-low reset
SELEC  in  3  store-mode opcode
RX_DATO  in  ANCHO_DATO  contents of register X
RY  in  ANCHO_RY  index of register Y
RY_DATO  in  ANCHO_DATO  contents of register Y
VALIDO  in  1  issue strobe, qualifies SELEC/RX/RY inputs
LISTO  out  1  FIFO can accept (not full)
DIR_OUT  out  ANCHO_DIR  bus address, registered
DATO_OUT  out  ANCHO_DATO  bus data, registered
ESC  out  1  bus write strobe
ACK  in  1  bus acknowledge, sampled only while ESC=1
PENDIENTES  out  $clog2(PROF)+1  occupied FIFO entries
ERROR  out  1  sticky timeout flag (tied 0 without SALIDAS_TIMEOUT_EN)

Behaviour:
- Reset (RST_N=0, asynchronous): FIFO empty, PENDIENTES=0, ESC=0, DIR_OUT=0, DATO_OUT=0, ERROR=0, state INACTIVO, LISTO=1 after release.
- Decode (combinational, per issue):
  - 3'b011: DIR=RY_DATO, DATO=0.
  - 3'b101: DIR=RX_DATO, DATO=zero-extended RY.
  - 3'b110: DIR=RX_DATO, DATO=RY_DATO.
  - Other codes are non-store: not enqueued, no error.
- Enqueue occurs when VALIDO & LISTO & store-mode code.
- LISTO = !full, from registered occupancy. When full, no enqueue occurs, even if a pop happens in the same cycle.
- VALIDO with LISTO=0 is dropped. The issuer must hold VALIDO until LISTO.
- Simultaneous enqueue and pop (not full) leaves PENDIENTES unchanged. Pointers wrap modulo PROF.
- FSM:
  - INACTIVO: if FIFO not empty, load DIR_OUT/DATO_OUT from head, ESC<=1, go to ESCRIBE.
  - ESCRIBE: ESC, DIR_OUT, DATO_OUT are held stable. On ACK=1: pop head, ESC<=0, go to LIBERA.
  - LIBERA: one cycle with ESC=0, outputs hold their last values. Then go to INACTIVO.
- Latency: an entry enqueued at edge N drives ESC=1 after edge N+1. Back-to-back writes are spaced by at least 3 cycles (ESC high >= 1, low 1, INACTIVO 1).
- ACK received outside ESCRIBE is ignored.
- Reset mid-transfer aborts the transfer. Queued entries are lost and ESC drops immediately.

Optional Feature:
SALIDAS_TIMEOUT_EN:
- Defined:
  - A counter runs while in ESCRIBE.
  - If ACK is still absent after TIMEOUT cycles with ESC high, the head is popped (write discarded), ERROR<=1 (sticky until reset), and the FSM goes to LIBERA.
  - If ACK arrives in the same cycle the counter expires, ACK wins and ERROR is not set.
- Undefined: no counter; ESCRIBE waits indefinitely; ERROR tied to 0.

Decomposition:
- Package salidas_pkg holds:
  - SELEC codes: SEL_DIR_RY=3'b011, SEL_RX_IDX=3'b101, SEL_RX_RY=3'b110.
  - State enum: INACTIVO, ESCRIBE, LIBERA.
  - Function for store-mode decode.
- Sub-module salidas_fifo: parameterised synchronous FIFO of {DIR,DATO} with push, pop, full, empty, and count outputs.

Test Plan:
- Reset then SELEC=110, RX_DATO=8'h20, RY_DATO=8'hA5, VALIDO 1 cycle, ACK tied 1 -> ESC high for exactly 1 cycle 2 cycles after issue, DIR_OUT=8'h20, DATO_OUT=8'hA5, PENDIENTES returns to 0.
- SELEC=101, RX_DATO=8'h07, RY=3'b110; then SELEC=011, RY_DATO=8'h3C -> two writes in order: (07,06) then (3C,00), separated by ESC-low cycle.
- ACK held 0, issue 5 store ops with PROF=4 -> LISTO=0 after 4th, 5th dropped; release ACK -> exactly 4 writes in FIFO order.
- SELEC=000/111 with VALIDO -> no enqueue, ESC stays 0, PENDIENTES=0.
- RST_N pulsed low while ESC=1 and PENDIENTES=3 -> ESC=0, outputs 0, PENDIENTES=0 immediately (asynchronous); no writes after release.
- With SALIDAS_TIMEOUT_EN, TIMEOUT=15, ACK never asserted -> ESC drops after 15 cycles high, ERROR=1 and stays 1; next queued write still issued.
